// File: rtl/udl_step_gen.sv
// Steps an external up/down counter towards a latched target with paced CE/UP pulses and pulses DONE on arrival.
// First CE two cycles after START; one step every DIV+3 cycles; ABORT wins over everything and returns to IDLE.
module udl_step_gen #(
    parameter int Width = 4,
    parameter int DIV_W = 8,
    parameter int TMR   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [Width-1:0] TGT,
    input  logic [Width-1:0] CUR,
    input  logic [DIV_W-1:0] DIV,
    output logic             CE,
    output logic             UP,
    output logic             BUSY,
    output logic             DONE,
    output logic [Width-1:0] STEP_CNT
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMP  = 3'd1,
        S_STEP = 3'd2,
        S_WAIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam int NC = (TMR != 0) ? 3 : 1;
    localparam int SW = 3 + Width + 1 + DIV_W + Width;

    logic [SW-1:0]    cp_vec [NC];
    logic [SW-1:0]    vote;
    logic [2:0]       state_raw;
    state_t           state_v, state_d;
    logic [Width-1:0] tgt_v, tgt_d;
    logic             dir_v, dir_d;
    logic [DIV_W-1:0] wait_v, wait_d;
    logic [Width-1:0] cnt_v, cnt_d;

    // Every copy loads the same next value, computed from the voted state.
    for (genvar c = 0; c < NC; c++) begin : g_cp
        logic [2:0]       state_q;
        logic [Width-1:0] tgt_q;
        logic             dir_q;
        logic [DIV_W-1:0] wait_q;
        logic [Width-1:0] cnt_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q <= S_IDLE;
                tgt_q   <= '0;
                dir_q   <= 1'b0;
                wait_q  <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                tgt_q   <= tgt_d;
                dir_q   <= dir_d;
                wait_q  <= wait_d;
                cnt_q   <= cnt_d;
            end
        end

        assign cp_vec[c] = {state_q, tgt_q, dir_q, wait_q, cnt_q};
    end

    if (TMR != 0) begin : g_vote
        assign vote = (cp_vec[0] & cp_vec[1]) | (cp_vec[0] & cp_vec[2]) | (cp_vec[1] & cp_vec[2]);
    end else begin : g_single
        assign vote = cp_vec[0];
    end

    assign {state_raw, tgt_v, dir_v, wait_v, cnt_v} = vote;
    assign state_v = state_t'(state_raw);

    always_comb begin
        state_d = state_v;
        tgt_d   = tgt_v;
        dir_d   = dir_v;
        wait_d  = wait_v;
        cnt_d   = cnt_v;
        case (state_v)
            S_IDLE: begin
                if (START && !ABORT) begin
                    tgt_d   = TGT;
                    cnt_d   = '0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (CUR == tgt_v) begin
                    state_d = S_FIN;
                end else begin
                    dir_d   = (tgt_v > CUR);
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                wait_d  = DIV;
                if (cnt_v != '1) begin
                    cnt_d = cnt_v + 1'b1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_v == '0) begin
                    state_d = S_CMP;
                end else begin
                    wait_d = wait_v - 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The step issued in an aborted STEP cycle still counts; only the state is cut short.
        if (ABORT && state_v != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    assign CE       = (state_v == S_STEP);
    assign UP       = dir_v;
    assign BUSY     = (state_v != S_IDLE);
    assign DONE     = (state_v == S_FIN);
    assign STEP_CNT = cnt_v;

endmodule

// File: tb/tb_udl_step_gen.sv
// Bench for udl_step_gen (TMR build) driving a behavioural up/down counter on the CE/UP interface.
module tb_udl_step_gen;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [3:0] TGT = '0;
    logic [3:0] CUR = '0;
    logic [7:0] DIV = '0;
    logic       CE, UP, BUSY, DONE;
    logic [3:0] STEP_CNT;

    logic       ld = 1'b0;
    logic [3:0] ld_val = '0;

    typedef struct {
        bit  is_done;
        bit  up;
        time t;
    } exp_t;

    typedef struct {
        int cur0;
        int tgt;
        int dv;
        int n_ce;
        bit up;
        int first;
        int gap;
        int done_off;
    } vec_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    time  t_s    = 0;

    udl_step_gen #(.Width(4), .DIV_W(8), .TMR(1)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .TGT(TGT), .CUR(CUR), .DIV(DIV),
        .CE(CE), .UP(UP), .BUSY(BUSY), .DONE(DONE), .STEP_CNT(STEP_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ld) CUR <= ld_val;
        else if (CE) CUR <= UP ? CUR + 4'd1 : CUR - 4'd1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Monitor: every CE or DONE pulse consumes one expected event.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (CE || DONE)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, DONE, CE}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {30'd0, DONE, CE}, e.is_done ? 2 : 1);
                chk("event_time", $time, e.t);
                if (!e.is_done) chk("ce_up", UP, e.up);
            end
        end
    end

    task automatic load_cur(input int v);
        @(negedge CLK); ld = 1'b1; ld_val = 4'(v);
        @(negedge CLK); ld = 1'b0;
    endtask

    task automatic start_move(input int tgt, input int dv);
        @(negedge CLK); TGT = 4'(tgt); DIV = 8'(dv); START = 1'b1; t_s = $time;
        @(negedge CLK); START = 1'b0; TGT = ~TGT;
    endtask

    task automatic push_ces(input int n, input bit up, input int first, input int gap);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.is_done = 1'b0; e.up = up; e.t = t_s + 10 * (first + k * gap);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input int off);
        exp_t e;
        e.is_done = 1'b1; e.up = 1'b0; e.t = t_s + 10 * off;
        exp_q.push_back(e);
    endtask

    task automatic wait_off(input int off);
        while ($time < t_s + 10 * off) @(negedge CLK);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        load_cur(v.cur0);
        start_move(v.tgt, v.dv);
        push_ces(v.n_ce, v.up, v.first, v.gap);
        push_done(v.done_off);
        wait_off(v.done_off + 1);
        chk({name, "_busy_after_done"}, BUSY, 0);
        chk({name, "_step_cnt"}, STEP_CNT, v.n_ce);
        chk({name, "_cur_at_target"}, CUR, v.tgt);
        chk({name, "_missing_events"}, exp_q.size(), 0);
    endtask

    vec_t vecs[4] = '{
        '{cur0: 2, tgt: 5, dv: 0, n_ce: 3, up: 1'b1, first: 2, gap: 3, done_off: 11},
        '{cur0: 9, tgt: 4, dv: 3, n_ce: 5, up: 1'b0, first: 2, gap: 6, done_off: 32},
        '{cur0: 7, tgt: 7, dv: 0, n_ce: 0, up: 1'b0, first: 2, gap: 3, done_off: 2},
        '{cur0: 6, tgt: 8, dv: 1, n_ce: 2, up: 1'b1, first: 2, gap: 4, done_off: 10}
    };

    initial begin
        #12;
        chk("rst_ce", CE, 0);
        chk("rst_up", UP, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_step_cnt", STEP_CNT, 0);
        @(negedge CLK); RST = 1'b0;

        run_vec(vecs[0], "up3");
        run_vec(vecs[1], "down5");
        run_vec(vecs[2], "zero");

        // Abort on the 4th CE of a 0->15 move: that CE still goes out, nothing after it.
        load_cur(0);
        start_move(15, 1);
        chk("busy_after_accept", BUSY, 1);
        push_ces(4, 1'b1, 2, 4);
        wait_off(14);
        ABORT = 1'b1;
        @(negedge CLK); ABORT = 1'b0;
        wait_off(20);
        chk("abort_busy", BUSY, 0);
        chk("abort_step_cnt", STEP_CNT, 4);
        chk("abort_missing_events", exp_q.size(), 0);
        @(negedge CLK); START = 1'b1; ABORT = 1'b1; TGT = 4'd9;
        @(negedge CLK); START = 1'b0; ABORT = 1'b0;
        chk("start_with_abort_busy", BUSY, 0);
        repeat (3) @(negedge CLK);
        chk("start_with_abort_step_cnt", STEP_CNT, 4);

        // Reset in the middle of a WAIT.
        load_cur(3);
        start_move(10, 2);
        push_ces(2, 1'b1, 2, 5);
        wait_off(9);
        #2 RST = 1'b1;
        #1;
        chk("rst_wait_ce", CE, 0);
        chk("rst_wait_busy", BUSY, 0);
        chk("rst_wait_done", DONE, 0);
        chk("rst_wait_step_cnt", STEP_CNT, 0);
        @(negedge CLK); RST = 1'b0;
        chk("rst_wait_missing_events", exp_q.size(), 0);

        // Reset while CE is high drops it before the next edge.
        load_cur(5);
        start_move(9, 0);
        push_ces(2, 1'b1, 2, 3);
        wait_off(5);
        #2 RST = 1'b1;
        #1;
        chk("rst_step_ce_drop", CE, 0);
        chk("rst_step_step_cnt", STEP_CNT, 0);
        @(negedge CLK); RST = 1'b0;
        run_vec(vecs[3], "after_rst");

        // 15 -> 0 with the counter reloaded to 15 after two steps: 17 steps, count saturates.
        load_cur(15);
        start_move(0, 0);
        push_ces(17, 1'b0, 2, 3);
        push_done(53);
        wait_off(6);
        ld = 1'b1; ld_val = 4'd15;
        @(negedge CLK); ld = 1'b0;
        wait_off(54);
        chk("sat_step_cnt", STEP_CNT, 15);
        chk("sat_cur", CUR, 0);
        chk("sat_missing_events", exp_q.size(), 0);

        // Single-copy upset: one state copy forced to FIN during WAIT.
        load_cur(1);
        start_move(4, 2);
        push_ces(3, 1'b1, 2, 5);
        push_done(17);
        wait_off(4);
        force dut.g_cp[1].state_q = 3'd4;
        #1;
        chk("upset_done", DONE, 0);
        chk("upset_busy", BUSY, 1);
        @(negedge CLK);
        release dut.g_cp[1].state_q;
        wait_off(18);
        chk("upset_step_cnt", STEP_CNT, 3);
        chk("upset_cur", CUR, 4);
        chk("upset_missing_events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
